// File: rtl/modu_mul_pkg.sv
// Shared definitions for the modu_mul_128 modular multiplier: FSM encoding,
// default operand width and bit-counter sizing.
package modu_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REDY = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REDY = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int NLEN_DEF = 128;
    localparam int CNT_W_DEF = $clog2(NLEN_DEF);

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/modu_mul_128_cond_sub.sv
// Combinational compare-and-subtract: out = v - m when m != 0 and v >= m,
// otherwise v unchanged. A zero modulus never subtracts.
module modu_cond_sub
    import modu_mul_pkg::*;
#(
    parameter int NLEN = NLEN_DEF
) (
    input  logic [NLEN+1:0] v,
    input  logic [NLEN-1:0] m,
    output logic [NLEN+1:0] out
);

    logic [NLEN+1:0] m_ext;
    logic            do_sub;

    assign m_ext  = {2'b00, m};
    assign do_sub = (m != '0) && (v >= m_ext);
    assign out    = do_sub ? (v - m_ext) : v;

endmodule

// File: rtl/modu_mul_128.sv
// Sequential modular multiplier p = (x * y) mod m: NLEN cycles reducing y mod m,
// then NLEN cycles of MSB-first interleaved multiply. Optional fast path for
// trivially-zero results is enabled by defining MODU_MUL_FAST_ZERO_EN.
module modu_mul_128
    import modu_mul_pkg::*;
#(
    parameter int NLEN = NLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            strobe,
    input  logic [NLEN-1:0] x,
    input  logic [NLEN-1:0] y,
    input  logic [NLEN-1:0] m,
    output logic [NLEN-1:0] p,
    output logic            ready,
    output logic            busy,
    output logic [1:0]      fsm_state
);

    localparam int CW = cnt_width(NLEN);
    localparam logic [CW-1:0] CNT_INIT = CW'(NLEN - 1);

    logic [1:0]      state;
    logic [NLEN-1:0] x_q;
    logic [NLEN-1:0] y_q;
    logic [NLEN-1:0] m_q;
    logic [NLEN-1:0] yr_q;
    logic [NLEN+1:0] acc;
    logic [CW-1:0]   cnt;
    logic            mul_last;
`ifdef MODU_MUL_FAST_ZERO_EN
    logic            fast_pend;
`endif

    logic [NLEN+1:0] sub1_in;
    logic [NLEN+1:0] sub1_out;
    logic [NLEN+1:0] sub2_out;
    logic [NLEN+1:0] addend;

    assign fsm_state = state;

    // In REDY the first subtractor reduces 2r + y_bit; in MUL both stages
    // reduce 2a + x_bit*yr, which stays below 3m.
    assign addend  = x_q[cnt] ? {2'b00, yr_q} : '0;
    assign sub1_in = (state == ST_REDY) ? ((acc << 1) | {{(NLEN+1){1'b0}}, y_q[cnt]})
                                        : ((acc << 1) + addend);

    modu_cond_sub #(.NLEN(NLEN)) u_sub1 (
        .v   (sub1_in),
        .m   (m_q),
        .out (sub1_out)
    );

    modu_cond_sub #(.NLEN(NLEN)) u_sub2 (
        .v   (sub1_out),
        .m   (m_q),
        .out (sub2_out)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= ST_IDLE;
            p        <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            m_q      <= '0;
            yr_q     <= '0;
            acc      <= '0;
            cnt      <= '0;
            mul_last <= 1'b0;
`ifdef MODU_MUL_FAST_ZERO_EN
            fast_pend <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
`ifdef MODU_MUL_FAST_ZERO_EN
                    if (fast_pend && !strobe) begin
                        p         <= '0;
                        ready     <= 1'b1;
                        fast_pend <= 1'b0;
                    end
`endif
                    if (strobe) begin
                        x_q      <= x;
                        y_q      <= y;
                        m_q      <= m;
                        ready    <= 1'b0;
                        acc      <= '0;
                        cnt      <= CNT_INIT;
                        mul_last <= 1'b0;
`ifdef MODU_MUL_FAST_ZERO_EN
                        if ((x == '0) || (y == '0) || (m <= NLEN'(1))) begin
                            fast_pend <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            fast_pend <= 1'b0;
                            busy      <= 1'b1;
                            state     <= ST_REDY;
                        end
`else
                        busy  <= 1'b1;
                        state <= ST_REDY;
`endif
                    end
                end
                ST_REDY: begin
                    if (cnt == '0) begin
                        yr_q  <= sub1_out[NLEN-1:0];
                        acc   <= '0;
                        cnt   <= CNT_INIT;
                        state <= ST_MUL;
                    end else begin
                        acc <= sub1_out;
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_MUL: begin
                    if (!mul_last) begin
                        acc <= sub2_out;
                        if (cnt == '0) begin
                            mul_last <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end else begin
                        // A zero modulus leaves the accumulator unreduced; its result is defined as 0.
                        p        <= (m_q == '0) ? '0 : acc[NLEN-1:0];
                        busy     <= 1'b0;
                        ready    <= 1'b1;
                        mul_last <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modu_mul_128.sv
// Directed and random bench for modu_mul_128 with an expected-result queue
// filled at strobe time and drained when ready rises.
module tb_modu_mul_128;

    localparam int NLEN = 128;
    localparam int W    = NLEN;

    logic          clk;
    logic          rst_n;
    logic          strobe;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [W-1:0]  m;
    logic [W-1:0]  p;
    logic          ready;
    logic          busy;
    logic [1:0]    fsm_state;

    logic [W-1:0]  exp_q[$];
    int            checks = 0;
    int            errors = 0;

    modu_mul_128 #(.NLEN(NLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strobe    (strobe),
        .x         (x),
        .y         (y),
        .m         (m),
        .p         (p),
        .ready     (ready),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_w();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                           input logic [W-1:0] mv);
        logic [2*W-1:0] prod;
        logic [2*W-1:0] rem;
        prod = {{W{1'b0}}, xv} * {{W{1'b0}}, yv};
        if (mv == '0) return '0;
        rem = prod % {{W{1'b0}}, mv};
        return rem[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: one strobe, optional ignored strobe mid-run, wait for ready, score
    task automatic run_op(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                          input logic [W-1:0] mv, input int inject);
        int   n;
        bit   fast;
        bit   busy_bad;
        int   exp_lat;
        exp_q.push_back(model(xv, yv, mv));
        fast = 1'b0;
`ifdef MODU_MUL_FAST_ZERO_EN
        fast = (xv == '0) || (yv == '0) || (mv <= W'(1));
`endif
        exp_lat = fast ? 1 : 2 * NLEN + 1;
        x = xv;
        y = yv;
        m = mv;
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        x = rand_w();
        y = rand_w();
        m = rand_w();
        check({tag, "_busy_at_start"}, W'(busy), W'(!fast));
        check({tag, "_ready_cleared"}, W'(ready), '0);
        n = 0;
        busy_bad = 1'b0;
        while (!ready && n < 600) begin
            if (n == inject) begin
                strobe = 1'b1;
                x = rand_w();
                y = rand_w();
                m = rand_w();
            end
            @(posedge clk);
            #1;
            strobe = 1'b0;
            n++;
            if (!ready && (busy !== !fast)) busy_bad = 1'b1;
            if (ready && busy) busy_bad = 1'b1;
        end
        check({tag, "_latency"}, W'(n), W'(exp_lat));
        check({tag, "_busy_profile"}, W'(busy_bad), '0);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue: observed empty expected entry", tag);
        end else begin
            check({tag, "_result"}, p, exp_q.pop_front());
        end
    endtask

    initial begin
        logic [W-1:0] ones;
        ones   = '1;
        rst_n  = 1'b1;
        strobe = 1'b0;
        x      = '0;
        y      = '0;
        m      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_p", p, '0);
        check("reset_ready", W'(ready), '0);
        check("reset_busy", W'(busy), '0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        run_op("op_15_25_7", W'(15), W'(25), W'(7), -1);
        run_op("op_5_13_17", W'(5), W'(13), W'(17), -1);
        run_op("op_16_16_17", W'(16), W'(16), W'(17), -1);
        run_op("op_all_ones", ones, ones, ones, -1);
        run_op("op_ones_m_odd", ones, ones - W'(2), W'(1000003), -1);
        run_op("op_ignore_strobe", W'(100), W'(200), W'(97), 50);

        // reset during MUL phase aborts the operation
        x = rand_w();
        y = rand_w();
        m = rand_w();
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check("pre_reset_busy", W'(busy), W'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_p", p, '0);
        check("midreset_ready", W'(ready), '0);
        check("midreset_busy", W'(busy), '0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        run_op("op_after_reset", W'(123456789), W'(987654321), W'(1000000007), -1);
        for (int i = 0; i < 3; i++) begin
            run_op("op_random", rand_w(), rand_w(), rand_w() | W'(1), -1);
        end
        run_op("op_m0", W'(9), W'(9), W'(0), -1);
        run_op("op_m1", W'(9), W'(9), W'(1), -1);
        run_op("op_x0", W'(0), rand_w(), W'(11), -1);
        run_op("op_y_gt_m", W'(3), W'($urandom_range(1000, 5000)), W'(13), -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
